// File: rtl/modport_pkt_proc_pkg.sv
// Shared constants, storage word layout and write-FSM states for the packet buffer.
package modport_pkt_proc_pkg;

   localparam int DEPTH  = 8192;
   localparam int ADDR_W = 13;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 12;
   localparam int LVL_W  = 14;
   localparam int THR_W  = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DROP  = 2'd2
   } wr_state_e;

   typedef struct packed {
      logic              sop;
      logic              eop;
      logic [DATA_W-1:0] data;
   } mem_word_t;

endpackage

// File: rtl/modport_pkt_proc_if.sv
// Write/read packet bus between a packet source/sink (master) and the buffer (slave).
interface modport_pkt_proc_if;
   import modport_pkt_proc_pkg::*;

   logic              enq_req;
   logic              in_sop;
   logic              in_eop;
   logic [DATA_W-1:0] wr_data_i;
   logic              pck_len_valid;
   logic [LEN_W-1:0]  pck_len_i;
   logic              deq_req;
   logic              out_sop;
   logic              out_eop;
   logic [DATA_W-1:0] rd_data_o;

   modport master (
      output enq_req, in_sop, in_eop, wr_data_i, pck_len_valid, pck_len_i, deq_req,
      input  out_sop, out_eop, rd_data_o
   );

   modport slave (
      input  enq_req, in_sop, in_eop, wr_data_i, pck_len_valid, pck_len_i, deq_req,
      output out_sop, out_eop, rd_data_o
   );

endinterface

// File: rtl/modport_pkt_proc_mem.sv
// Simple dual-port word store with a 1-cycle registered read; the read register holds between reads.
module pkt_proc_mem
   import modport_pkt_proc_pkg::*;
(
   input  logic              gclk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  mem_word_t         wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output mem_word_t         rdata
);

   mem_word_t mem [DEPTH];

   always_ff @(posedge gclk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Only the output register is cleared; the array itself is never reset.
   always_ff @(posedge gclk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/modport_pkt_proc.sv
// Packet buffer: length-checked write FSM with drop/rewind, store-and-forward or cut-through read.
module modport_pkt_proc
   import modport_pkt_proc_pkg::*;
(
   input  logic               pck_proc_int_mem_fsm_clk,
   input  logic               pck_proc_int_mem_fsm_rstn,
   input  logic               pck_proc_int_mem_fsm_sw_rstn,
   input  logic               empty_de_assert,
   modport_pkt_proc_if.slave  bus,
   input  logic [THR_W-1:0]   pck_proc_almost_full_value,
   input  logic [THR_W-1:0]   pck_proc_almost_empty_value,
   output logic               pck_proc_full,
   output logic               pck_proc_empty,
   output logic               pck_proc_almost_full,
   output logic               pck_proc_almost_empty,
   output logic               pck_proc_overflow,
   output logic               pck_proc_underflow,
   output logic               packet_drop,
   output logic [LVL_W-1:0]   pck_proc_wr_lvl
);

   wr_state_e         state, state_n;
   logic [ADDR_W-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
   logic [LVL_W-1:0]  wr_lvl_n, cmt_lvl, cmt_lvl_n, pkt_cnt, pkt_cnt_n;
   logic [LVL_W-1:0]  readable, readable_n, free_sp, rewind;
   logic [LEN_W-1:0]  pkt_len, pkt_len_n;
   logic              rst, we, do_rd, rd_cmt, commit, drop, ovf;
   mem_word_t         wr_word, rd_word;

   assign rst      = !pck_proc_int_mem_fsm_rstn || !pck_proc_int_mem_fsm_sw_rstn;
   // cmt_lvl counts committed unread words; everything above it belongs to the open packet.
   assign readable = empty_de_assert ? pck_proc_wr_lvl : cmt_lvl;
   assign free_sp  = LVL_W'(DEPTH) - pck_proc_wr_lvl;
   assign do_rd    = bus.deq_req && (readable != '0);
   assign rd_cmt   = do_rd && (cmt_lvl != '0);
   assign ovf      = bus.enq_req && pck_proc_full;

   always_comb begin
      state_n   = state;
      pkt_len_n = pkt_len;
      pkt_cnt_n = pkt_cnt;
      we        = 1'b0;
      commit    = 1'b0;
      drop      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.enq_req && bus.in_sop) begin
               if (bus.pck_len_valid && (bus.pck_len_i != '0) &&
                   (LVL_W'(bus.pck_len_i) <= free_sp) &&
                   (!bus.in_eop || (bus.pck_len_i == LEN_W'(1)))) begin
                  we        = 1'b1;
                  pkt_len_n = bus.pck_len_i;
                  pkt_cnt_n = LVL_W'(1);
                  if (bus.in_eop) commit  = 1'b1;
                  else            state_n = WRITE;
               end else begin
                  drop    = 1'b1;
                  state_n = bus.in_eop ? IDLE : DROP;
               end
            end
         end
         WRITE: begin
            if (bus.enq_req) begin
               if (ovf || bus.in_sop ||
                   (bus.in_eop && ((pkt_cnt + LVL_W'(1)) != LVL_W'(pkt_len)))) begin
                  drop    = 1'b1;
                  state_n = bus.in_eop ? IDLE : DROP;
               end else begin
                  we        = 1'b1;
                  pkt_cnt_n = pkt_cnt + LVL_W'(1);
                  if (bus.in_eop) begin
                     commit  = 1'b1;
                     state_n = IDLE;
                  end
               end
            end
         end
         DROP: begin
            if (bus.enq_req && bus.in_eop) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_n  = wr_ptr + ADDR_W'(we);
      rd_ptr_n  = rd_ptr + ADDR_W'(do_rd);
      wr_lvl_n  = pck_proc_wr_lvl + LVL_W'(we) - LVL_W'(do_rd);
      cmt_lvl_n = cmt_lvl - LVL_W'(rd_cmt);
      // Open-packet words still unread after this cycle's read; a drop takes back exactly these.
      rewind    = pck_proc_wr_lvl - cmt_lvl - LVL_W'(do_rd && !rd_cmt);
      if (commit) cmt_lvl_n = wr_lvl_n;
      if (drop) begin
         wr_ptr_n = wr_ptr - ADDR_W'(rewind);
         wr_lvl_n = cmt_lvl_n;
      end
      readable_n = empty_de_assert ? wr_lvl_n : cmt_lvl_n;
   end

   always_ff @(posedge pck_proc_int_mem_fsm_clk) begin
      if (rst) begin
         state                 <= IDLE;
         wr_ptr                <= '0;
         rd_ptr                <= '0;
         pck_proc_wr_lvl       <= '0;
         cmt_lvl               <= '0;
         pkt_cnt               <= '0;
         pkt_len               <= '0;
         pck_proc_full         <= 1'b0;
         pck_proc_empty        <= 1'b1;
         pck_proc_almost_full  <= 1'b0;
         pck_proc_almost_empty <= 1'b1;
         pck_proc_overflow     <= 1'b0;
         pck_proc_underflow    <= 1'b0;
         packet_drop           <= 1'b0;
      end else begin
         state                 <= state_n;
         wr_ptr                <= wr_ptr_n;
         rd_ptr                <= rd_ptr_n;
         pck_proc_wr_lvl       <= wr_lvl_n;
         cmt_lvl               <= cmt_lvl_n;
         pkt_cnt               <= pkt_cnt_n;
         pkt_len               <= pkt_len_n;
         pck_proc_full         <= (wr_lvl_n == LVL_W'(DEPTH));
         pck_proc_empty        <= (readable_n == '0);
         pck_proc_almost_full  <= (wr_lvl_n >= (LVL_W'(DEPTH) - LVL_W'(pck_proc_almost_full_value)));
         pck_proc_almost_empty <= (wr_lvl_n <= LVL_W'(pck_proc_almost_empty_value));
         pck_proc_overflow     <= ovf;
         pck_proc_underflow    <= bus.deq_req && (readable == '0);
         packet_drop           <= drop;
      end
   end

   assign wr_word = '{sop: bus.in_sop, eop: bus.in_eop, data: bus.wr_data_i};

   pkt_proc_mem u_mem (
      .gclk  (pck_proc_int_mem_fsm_clk),
      .rst   (rst),
      .we    (we && !rst),
      .waddr (wr_ptr),
      .wdata (wr_word),
      .re    (do_rd),
      .raddr (rd_ptr),
      .rdata (rd_word)
   );

   assign bus.rd_data_o = rd_word.data;
   assign bus.out_sop   = rd_word.sop;
   assign bus.out_eop   = rd_word.eop;

endmodule

// File: tb/tb_modport_pkt_proc.sv
// Random and directed packet traffic against a queue-based reference of the buffer's packet rules.
module tb_modport_pkt_proc;
   import modport_pkt_proc_pkg::*;

   logic       clk = 1'b0;
   logic       rstn = 1'b0, sw_rstn = 1'b1, ea = 1'b0;
   logic [4:0] afv = 5'd4, aev = 5'd2;
   logic       full, empty, afull, aempty, ovf, udf, drop;
   logic [13:0] lvl;

   modport_pkt_proc_if bus();

   modport_pkt_proc dut (
      .pck_proc_int_mem_fsm_clk    (clk),
      .pck_proc_int_mem_fsm_rstn   (rstn),
      .pck_proc_int_mem_fsm_sw_rstn(sw_rstn),
      .empty_de_assert             (ea),
      .bus                         (bus),
      .pck_proc_almost_full_value  (afv),
      .pck_proc_almost_empty_value (aev),
      .pck_proc_full               (full),
      .pck_proc_empty              (empty),
      .pck_proc_almost_full        (afull),
      .pck_proc_almost_empty       (aempty),
      .pck_proc_overflow           (ovf),
      .pck_proc_underflow          (udf),
      .packet_drop                 (drop),
      .pck_proc_wr_lvl             (lvl)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        sop;
      logic        eop;
      logic [31:0] data;
   } word_t;

   // Reference: unread words in arrival order; the first n_cmt of them belong to finished packets.
   word_t       stored[$];
   int          n_cmt, plen, pcnt;
   bit          in_pkt, skipping;
   logic [31:0] e_data;
   bit          e_sop, e_eop, e_ovf, e_udf, e_drop, e_full, e_af;
   bit          e_empty = 1'b1, e_ae = 1'b1;
   int          n_chk, n_err;

   task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int  sz, rdbl;
      bit  rd, wr, commit, dropn;
      word_t w;
      if (!rstn || !sw_rstn) begin
         stored.delete();
         n_cmt = 0; in_pkt = 0; skipping = 0;
         e_data = '0; e_sop = 0; e_eop = 0;
         e_ovf = 0; e_udf = 0; e_drop = 0; e_full = 0; e_af = 0;
         e_empty = 1; e_ae = 1;
         return;
      end
      sz     = stored.size();
      rdbl   = ea ? sz : n_cmt;
      rd     = bus.deq_req && rdbl > 0;
      e_udf  = bus.deq_req && rdbl == 0;
      e_ovf  = bus.enq_req && sz == DEPTH;
      wr = 0; commit = 0; dropn = 0;
      if (bus.enq_req) begin
         if (skipping) begin
            if (bus.in_eop) skipping = 0;
         end else if (!in_pkt) begin
            if (bus.in_sop) begin
               if (bus.pck_len_valid && bus.pck_len_i != 0 && int'(bus.pck_len_i) <= DEPTH - sz &&
                   (!bus.in_eop || bus.pck_len_i == 1)) begin
                  wr = 1; plen = int'(bus.pck_len_i); pcnt = 1;
                  if (bus.in_eop) commit = 1; else in_pkt = 1;
               end else begin
                  dropn = 1; skipping = !bus.in_eop;
               end
            end
         end else begin
            if (e_ovf || bus.in_sop || (bus.in_eop && pcnt + 1 != plen)) begin
               dropn = 1; in_pkt = 0; skipping = !bus.in_eop;
            end else begin
               wr = 1; pcnt++;
               if (bus.in_eop) begin commit = 1; in_pkt = 0; end
            end
         end
      end
      if (rd) begin
         w = stored.pop_front();
         e_data = w.data; e_sop = w.sop; e_eop = w.eop;
         if (n_cmt > 0) n_cmt--;
      end
      if (wr) stored.push_back('{sop: bus.in_sop, eop: bus.in_eop, data: bus.wr_data_i});
      if (commit) n_cmt = stored.size();
      if (dropn) while (stored.size() > n_cmt) void'(stored.pop_back());
      e_drop  = dropn;
      sz      = stored.size();
      e_full  = sz == DEPTH;
      e_af    = sz >= DEPTH - int'(afv);
      e_ae    = sz <= int'(aev);
      e_empty = (ea ? sz : n_cmt) == 0;
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk); #1;
      chk("wr_lvl",    32'(lvl),           32'(stored.size()));
      chk("empty",     32'(empty),         32'(e_empty));
      chk("full",      32'(full),          32'(e_full));
      chk("alm_full",  32'(afull),         32'(e_af));
      chk("alm_empty", 32'(aempty),        32'(e_ae));
      chk("overflow",  32'(ovf),           32'(e_ovf));
      chk("underflow", 32'(udf),           32'(e_udf));
      chk("pkt_drop",  32'(drop),          32'(e_drop));
      chk("rd_data",   bus.rd_data_o,      e_data);
      chk("out_sop",   32'(bus.out_sop),   32'(e_sop));
      chk("out_eop",   32'(bus.out_eop),   32'(e_eop));
   endtask

   function automatic bit rnd(int pct);
      return int'($urandom_range(99)) < pct;
   endfunction

   task automatic drive(bit e, bit s, bit eo, logic [31:0] d, bit lv, logic [11:0] l, bit dq);
      bus.enq_req = e; bus.in_sop = s; bus.in_eop = eo; bus.wr_data_i = d;
      bus.pck_len_valid = lv; bus.pck_len_i = l; bus.deq_req = dq;
      cyc();
   endtask

   task automatic idle(int n, int dq_pct);
      for (int i = 0; i < n; i++) drive(0, 0, 0, $urandom, 0, 12'd0, rnd(dq_pct));
   endtask

   task automatic send_pkt(int nw, int len, bit lv, logic [31:0] base, int dq_pct, int sop_at);
      for (int i = 0; i < nw; i++)
         drive(1, i == 0 || i == sop_at, i == nw - 1, base + 32'(i), lv, 12'(len), rnd(dq_pct));
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 12'd0, 0);
      drive(0, 0, 0, 0, 0, 12'd0, 1);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_lvl", 32'(lvl), 32'd0);
      rstn = 1'b1;

      // length-4 store-and-forward round trip
      send_pkt(4, 4, 1, 32'hA0A0_0000, 0, -1);
      chk("r35_lvl4", 32'(lvl), 32'd4);
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 0, 12'd0, 1);
         chk("r35_data", bus.rd_data_o, 32'hA0A0_0000 + 32'(i));
         chk("r35_sop", 32'(bus.out_sop), 32'(i == 0));
         chk("r35_eop", 32'(bus.out_eop), 32'(i == 3));
      end
      chk("r35_lvl0", 32'(lvl), 32'd0);

      // early eop against declared length 3
      send_pkt(2, 3, 1, 32'h3600_0000, 0, -1);
      chk("r36_drop", 32'(drop), 32'd1);
      chk("r36_lvl", 32'(lvl), 32'd0);
      chk("r36_empty", 32'(empty), 32'd1);
      idle(1, 0);
      chk("r36_drop_end", 32'(drop), 32'd0);

      // empty visibility in both modes
      ea = 1'b0;
      drive(1, 1, 0, 32'h3700_0000, 1, 12'd4, 0);
      drive(1, 0, 0, 32'h3700_0001, 1, 12'd4, 0);
      chk("r37_saf_empty", 32'(empty), 32'd1);
      drive(1, 0, 0, 32'h3700_0002, 1, 12'd4, 0);
      drive(1, 0, 1, 32'h3700_0003, 1, 12'd4, 0);
      chk("r37_saf_cmt", 32'(empty), 32'd0);
      idle(4, 100);
      ea = 1'b1;
      drive(1, 1, 0, 32'h3710_0000, 1, 12'd4, 0);
      chk("r37_ct_empty", 32'(empty), 32'd0);
      send_pkt(3, 4, 1, 32'h3710_0001, 0, 99);
      idle(4, 100);
      ea = 1'b0;

      // read from an empty buffer
      drive(0, 0, 0, 0, 0, 12'd0, 1);
      chk("r38_udf", 32'(udf), 32'd1);
      chk("r38_lvl", 32'(lvl), 32'd0);
      idle(1, 0);
      chk("r38_udf_end", 32'(udf), 32'd0);

      // mixed random traffic with malformed packets
      for (int k = 0; k < 400; k++) begin
         int nw, len, sat;
         bit lv;
         ea  = ($urandom_range(3) == 0);
         afv = 5'($urandom);
         aev = 5'($urandom);
         nw  = $urandom_range(1, 8);
         len = nw; lv = 1; sat = -1;
         case ($urandom_range(11))
            0: lv = 0;
            1: len = $urandom_range(1, 8);
            2: len = 0;
            3: sat = $urandom_range(1, 7);
            default: ;
         endcase
         if ($urandom_range(9) == 0) drive(1, 0, 0, $urandom, 1, 12'd3, 0);
         send_pkt(nw, len, lv, $urandom, 40, sat);
         idle($urandom_range(0, 3), 60);
      end

      // fill to capacity, then overflow
      ea = 1'b0; afv = 5'd10; aev = 5'd2;
      rstn = 1'b0; idle(1, 0); rstn = 1'b1;
      send_pkt(4095, 4095, 1, 32'h0001_0000, 0, -1);
      send_pkt(4095, 4095, 1, 32'h0002_0000, 0, -1);
      chk("r39_af", 32'(afull), 32'd1);
      chk("r39_not_full", 32'(full), 32'd0);
      send_pkt(2, 2, 1, 32'h0003_0000, 0, -1);
      chk("r39_full", 32'(full), 32'd1);
      chk("r39_lvl", 32'(lvl), 32'd8192);
      drive(1, 1, 1, 32'hDEAD_BEEF, 1, 12'd1, 0);
      chk("r39_ovf", 32'(ovf), 32'd1);
      chk("r39_drop", 32'(drop), 32'd1);
      drive(1, 0, 0, 32'hDEAD_BEEF, 1, 12'd1, 0);
      chk("r39_ovf2", 32'(ovf), 32'd1);
      idle(1, 0);
      chk("r39_ovf_end", 32'(ovf), 32'd0);

      // soft reset mid-packet
      rstn = 1'b0; idle(1, 0); rstn = 1'b1;
      send_pkt(2, 2, 1, 32'h4000_0000, 0, -1);
      send_pkt(2, 5, 1, 32'h4100_0000, 0, 99);
      sw_rstn = 1'b0;
      drive(1, 0, 0, 32'h4100_0002, 1, 12'd5, 1);
      chk("r40_lvl", 32'(lvl), 32'd0);
      chk("r40_empty", 32'(empty), 32'd1);
      chk("r40_data", bus.rd_data_o, 32'd0);
      sw_rstn = 1'b1;
      drive(1, 1, 1, 32'h4200_0000, 1, 12'd1, 0);
      chk("r40_idle_commit", 32'(lvl), 32'd1);
      chk("r40_no_drop", 32'(drop), 32'd0);
      idle(2, 100);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/modport_pkt_proc.md
MODPORT_PKT_PROC -- requirements
Module: modport_pkt_proc

Interface
REQ-001 SHALL have port pck_proc_int_mem_fsm_clk, in, 1 bit: single clock; all logic on its rising edge.
REQ-002 SHALL have port pck_proc_int_mem_fsm_rstn, in, 1 bit: synchronous active-low reset.
REQ-003 SHALL have port pck_proc_int_mem_fsm_sw_rstn, in, 1 bit: synchronous active-low soft reset, same effect as REQ-002.
REQ-004 SHALL have port empty_de_assert, in, 1 bit: 1 = cut-through empty, 0 = store-and-forward empty.
REQ-005 SHALL have write ports enq_req, in_sop, in_eop (in, 1 bit each) and wr_data_i (in, 32 bits).
REQ-006 SHALL have ports pck_len_valid (in, 1 bit) and pck_len_i (in, 12 bits): packet length in 32-bit words, sampled with in_sop.
REQ-007 SHALL have read ports deq_req (in, 1 bit), out_sop and out_eop (out, 1 bit each), rd_data_o (out, 32 bits).
REQ-008 SHALL have threshold inputs pck_proc_almost_full_value and pck_proc_almost_empty_value, in, 5 bits each.
REQ-009 SHALL have 1-bit status outputs pck_proc_full, pck_proc_empty, pck_proc_almost_full, pck_proc_almost_empty, pck_proc_overflow, pck_proc_underflow and packet_drop.
REQ-010 SHALL have output pck_proc_wr_lvl, out, 14 bits: words currently stored.

Function
REQ-011 SHALL store words in a DEPTH=8192 x 34-bit memory holding data, sop and eop, with 13-bit wrapping read and write pointers.
REQ-012 SHALL use write FSM states IDLE, WRITE and DROP.
REQ-013 IDLE: enq_req & in_sop & pck_len_valid & pck_len_i!=0 & length <= free space -> write word and go to WRITE; with in_eop and length 1 it SHALL commit and stay in IDLE.
REQ-014 IDLE: a start with zero length, no pck_len_valid, or length > free space SHALL pulse packet_drop and go to DROP; enq_req without in_sop SHALL be ignored.
REQ-015 WRITE: each enq_req SHALL write one word and increment the word count.
REQ-016 WRITE: in_eop with count == length SHALL commit the packet and go to IDLE.
REQ-017 WRITE: a mismatched in_eop or a new in_sop SHALL trigger a drop.
REQ-018 On a drop, the write pointer and wr_lvl SHALL rewind to the packet start and packet_drop SHALL pulse for 1 cycle.
REQ-019 DROP SHALL discard words until in_eop, then return to IDLE.
REQ-020 deq_req when a readable word exists SHALL output the data and sop/eop on rd_data_o/out_sop/out_eop one cycle later, registered; outputs SHALL hold otherwise.
REQ-021 deq_req with no readable word SHALL pulse pck_proc_underflow for 1 cycle and leave pointers unchanged.
REQ-022 enq_req while pck_proc_full SHALL pulse pck_proc_overflow for 1 cycle, discard the word and drop the packet.
REQ-023 Simultaneous enqueue and dequeue SHALL both proceed with wr_lvl unchanged.
REQ-024 Readable words: committed words when empty_de_assert=0; all written words when empty_de_assert=1.
REQ-025 pck_proc_empty SHALL be asserted when readable words = 0.
REQ-026 pck_proc_full SHALL be asserted when wr_lvl == DEPTH.
REQ-027 pck_proc_almost_full SHALL be asserted when wr_lvl >= DEPTH - almost_full_value.
REQ-028 pck_proc_almost_empty SHALL be asserted when wr_lvl <= almost_empty_value.
REQ-029 All status flags SHALL be registered, reflecting state after the current edge.

Reset
REQ-030 Either reset low at a clock edge SHALL clear pointers, wr_lvl, FSM (to IDLE), rd_data_o, out_sop, out_eop, overflow, underflow, packet_drop, full, almost_full, and set empty=1 and almost_empty=1.
REQ-031 Reset SHALL have priority over all activity; a partial packet in progress SHALL be discarded.
REQ-032 Memory contents SHALL not require reset.

Structure
REQ-033 A shared package SHALL define DEPTH, the data width (32), the length width (12), the level width (14) and the FSM state enum.
REQ-034 Storage SHALL be one sub-module, pkt_proc_mem: a simple dual-port RAM with 1-cycle registered read.

Verification
REQ-035 Length-4 packet (sop, 4 words A0..A3, eop) then 4 deq_req -> rd_data_o A0..A3; out_sop with A0, out_eop with A3; wr_lvl 4 then 0.
REQ-036 pck_len_i=3, eop on word 2 -> packet_drop pulse; wr_lvl returns to prior value; empty stays 1.
REQ-037 empty_de_assert=0, 2 words of a length-4 packet written -> empty=1; after eop -> empty=0. With empty_de_assert=1 -> empty=0 after the first word.
REQ-038 deq_req on an empty buffer -> underflow 1-cycle pulse, wr_lvl=0.
REQ-039 Fill to 8192 words -> full=1; almost_full asserted at wr_lvl=8192-value; further enq_req -> overflow pulse.
REQ-040 sw_rstn low mid-packet -> all outputs at reset values next cycle; FSM in IDLE.
